mips_imem_loader: RTL
=====================

Name: mips_imem_loader

Overview:
Boot loader that writes the instruction memory the MIPS monocycle core fetches from. It accepts a byte stream (valid/ready): a 2-byte big-endian word count, then that many 32-bit big-endian instruction words. It packs the bytes into words and drives write pulses into instruction memory. It holds the core in reset until the whole program has been written.

Parameters:
ADDR_WIDTH, 6, instruction-memory word-address width; depth = 2**ADDR_WIDTH words
COUNT_WIDTH, 16, width of the header word-count field (fixed at 2 bytes)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data
in_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle request to restart loading (honoured in S_DONE only)
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_WIDTH  word address of current write
imem_wdata  output  32  instruction word being written
cpu_rst  output  1  reset to MIPS core, high while loading
done  output  1  program fully loaded
error  output  1  header count exceeded depth; sticky until rst

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port rst. rst dominates every other input on the same edge.
- Reset values: state=S_HDR_HI, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, internal counters=0.
- Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1. in_valid may assert with no dependency on in_ready. in_data is ignored without a transfer.
- All outputs are registered. in_ready is a function of the registered state only.
- States:
  - S_HDR_HI: transfer -> count[15:8]=in_data, go S_HDR_LO.
  - S_HDR_LO: transfer -> count[7:0]=in_data, then one of:
    - full count = 0 -> S_DONE
    - full count > 2**ADDR_WIDTH -> S_ERR
    - otherwise -> S_DATA, with word_idx=0 and byte_idx=0.
  - S_DATA: each transfer shifts the byte in, MSB first (first byte = bits 31:24); byte_idx increments. On the 4th byte, S_WRITE is entered with imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - S_WRITE: exactly one cycle, in_ready=0. Next state: S_DONE if word_idx == count-1, else S_DATA with word_idx+1 and byte_idx=0. imem_we returns to 0.
  - S_DONE: in_ready=0, done=1, cpu_rst=0. Both are set on the same edge as the S_DONE entry. If reload=1: go S_HDR_HI, done=0, cpu_rst=1, counters cleared.
  - S_ERR: in_ready=0, error=1, cpu_rst=1. Only rst leaves this state.
- Latency: 4th data byte accepted at edge k -> imem_we/addr/wdata valid between edge k and edge k+1, and memory commits at edge k+1. Earliest next byte acceptance is edge k+2. Sustained throughput is 1 word per 5 cycles.
- Boundaries:
  - count = 2**ADDR_WIDTH is legal. The last address is all-ones, and imem_addr never wraps.
  - reload outside S_DONE is ignored.
  - in_valid held high in S_WRITE/S_DONE/S_ERR: no transfer, no state change.
  - rst mid-word discards the partial word. No further imem_we is issued. cpu_rst stays 1.

Decomposition:
- Shared package mips_pkg:
  - loader_state_t enum (S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE, S_ERR)
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
- One natural sub-module, byte_packer: 8->32 big-endian shift register with byte counter. It has a clear input and a word_ready flag. The FSM, counters and output registers stay in mips_imem_loader.

Test Plan:
- Reset -> cpu_rst=1, in_ready=1, done=0, error=0, imem_we=0 on the first edge after rst.
- Stream 00 02 | 20 10 00 05 | 20 11 00 07, in_valid always high:
  - two imem_we pulses: addr 0 data 0x20100005, then addr 1 data 0x20110007
  - in_ready=0 during each S_WRITE cycle
  - done=1 and cpu_rst=0 one edge after the second pulse.
- Header 00 00 -> S_DONE directly, no imem_we ever, done=1 two transfers after reset.
- Header 00 41 with ADDR_WIDTH=6 (65 > 64) -> error=1, in_ready=0, cpu_rst=1, no writes. Extra bytes are ignored until rst.
- Header 00 40 plus 64 words with random in_valid gaps -> 64 pulses, addresses 0..63 in order, last addr 0x3F, no wrap, data matches.
- Reload and mid-operation reset:
  - reload pulse in S_DONE, then a 1-word stream -> done drops and cpu_rst rises on the next edge, and the new word is written to addr 0.
  - rst after 2 bytes of a word -> no imem_we, and the subsequent full load starts from header.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
package mips_pkg;

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/mips_imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the boot loader.
interface mips_imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/byte_packer.sv
// 8->32 big-endian packer: first byte lands in bits 31:24, word_ready flags the 4th byte.
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_ready
);

    // Only three bytes are stored; the fourth is merged combinationally.
    logic [23:0] shreg_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word_next  = {shreg_q, byte_in};
    assign word_ready = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_imem_loader.sv
// Boot loader: parses a counted big-endian word stream into imem writes, holding the core
// in reset until the whole program is written.
module mips_imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned COUNT_WIDTH = HDR_BYTES * 8
) (
    input  logic               clk,
    input  logic               rst,
    mips_imem_loader_if.slave  bus,
    input  logic               reload,
    output logic               cpu_rst,
    output logic               done,
    output logic               error
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    loader_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    fire;
    logic                    pack_clear;
    logic [31:0]             word_next;
    logic                    word_ready;
    logic [COUNT_WIDTH-1:0]  hdr_count;
    logic                    last_word;

    assign bus.in_ready = state_q inside {S_HDR_HI, S_HDR_LO, S_DATA};
    assign fire         = bus.in_valid && bus.in_ready;
    // Header bytes shift in MSB first; count_q is zero before the first header byte.
    assign hdr_count    = {count_q[COUNT_WIDTH-9:0], bus.in_data};
    assign last_word    = COUNT_WIDTH'(word_idx_q) == (count_q - COUNT_WIDTH'(1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .shift_en   (fire && (state_q == S_DATA)),
        .byte_in    (bus.in_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR_HI;
            count_q    <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        error_d    = error_q;
        pack_clear = 1'b0;

        case (state_q)
            S_HDR_HI: begin
                if (fire) begin
                    count_d = hdr_count;
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (fire) begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else if (32'(hdr_count) > Depth) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = '0;
                        pack_clear = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (word_ready) begin
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    addr_d  = word_idx_q;
                    wdata_d = word_next;
                end
            end
            S_WRITE: begin
                pack_clear = 1'b1;
                if (last_word) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                end else begin
                    state_d    = S_DATA;
                    word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (reload) begin
                    state_d    = S_HDR_HI;
                    done_d     = 1'b0;
                    cpu_rst_d  = 1'b1;
                    count_d    = '0;
                    word_idx_d = '0;
                    pack_clear = 1'b1;
                end
            end
            S_ERR: begin
                cpu_rst_d = 1'b1;
            end
            default: state_d = S_HDR_HI;
        endcase
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule
